spkr_driver: RTL



---
 rtl/spkr_driver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spkr_driver.sv
// spkr_driver: output stage between the melody tone generator and the
// board speaker pin. Gates the square-wave tone with a PWM carrier whose
// duty is a volume that ramps one step per RAMP_MS toward its target.
// The target is 0 while muted or while the input has had no edge for
// IDLE_MS, so silence and mute both fade out without clicks.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   spkr_in  - raw square wave from the tone generator (same clock domain)
//   vol      - target volume, 0 = silent, max = (2^PWM_BITS-1)/2^PWM_BITS duty
//   mute     - level, forces the target volume to 0
//   spkr_out - registered gated speaker drive (2 clocks after spkr_in)
//   cur_vol  - registered current (ramped) volume
//   active   - high whenever the ramp state is not SILENT
module spkr_driver #(
    parameter int FCLK     = 50000000,
    parameter int PWM_BITS = 4,
    parameter int RAMP_MS  = 2,
    parameter int IDLE_MS  = 50
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                spkr_in,
    input  logic [PWM_BITS-1:0] vol,
    input  logic                mute,
    output logic                spkr_out,
    output logic [PWM_BITS-1:0] cur_vol,
    output logic                active
);

    localparam int DIV    = FCLK / 1000;
    localparam int DIV_W  = $clog2(DIV);
    localparam int RAMP_W = $clog2(RAMP_MS + 1);
    localparam int IDLE_W = $clog2(IDLE_MS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_MS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_MS);

    typedef enum logic [1:0] {
        SILENT,
        RISE,
        STEADY,
        FALL
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                spkr_in_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] target;
    logic                in_edge;
    logic                ms_tick;
    logic                idle;
    logic                gate;

    assign in_edge = spkr_in ^ spkr_in_q;
    assign ms_tick = (div_cnt == DIV_LAST);
    assign idle    = (idle_cnt == IDLE_MAX);
    assign gate    = (pwm_cnt < cur_vol);

    always_comb begin
        target = vol;
        if (mute || idle) begin
            target = '0;
        end
    end

    // Input sampling, 1 ms divider and input-idle detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spkr_in_q <= 1'b0;
            div_cnt   <= '0;
            idle_cnt  <= IDLE_MAX;
        end else begin
            spkr_in_q <= spkr_in;
            if (ms_tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // An edge coinciding with ms_tick must still clear the count.
            if (in_edge) begin
                idle_cnt <= '0;
            end else if (ms_tick && !idle) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Volume ramp: one step per RAMP_MS ticks, direction chosen at each step
    // so a target change mid-ramp can reverse without overshooting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp_cnt <= '0;
            cur_vol  <= '0;
        end else if (cur_vol == target) begin
            ramp_cnt <= '0;
        end else if (ms_tick) begin
            if (ramp_cnt == RAMP_LAST) begin
                ramp_cnt <= '0;
                if (cur_vol < target) begin
                    cur_vol <= cur_vol + 1'b1;
                end else begin
                    cur_vol <= cur_vol - 1'b1;
                end
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end

    // PWM carrier and gated output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt  <= '0;
            spkr_out <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            spkr_out <= spkr_in_q & gate;
        end
    end

    // State follows the registered cur_vol, so active drops one cycle after
    // cur_vol reaches 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SILENT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SILENT: begin
                if (target != '0) begin
                    state_next = RISE;
                end
            end
            RISE, FALL: begin
                if (target > cur_vol) begin
                    state_next = RISE;
                end else if (target < cur_vol) begin
                    state_next = FALL;
                end else if (cur_vol == '0) begin
                    state_next = SILENT;
                end else begin
                    state_next = STEADY;
                end
            end
            STEADY: begin
                if (target > cur_vol) begin
                    state_next = RISE;
                end else if (target < cur_vol) begin
                    state_next = FALL;
                end
            end
            default: state_next = SILENT;
        endcase
    end

    always_comb begin
        active = (state != SILENT);
    end

endmodule
